// File: rtl/pfft_dout_serializer.sv
// pfft_dout_serializer
// Captures one parallel FFT output frame (2**FFT_ORDER complex samples) per
// din_valid pulse into a two-bank ping-pong buffer. Each frame is streamed out
// one sample per beat on an AXI-Stream-style master port, with tlast on the
// final sample and the stream position on tuser.
//
// Handshake: a beat transfers on a rising edge where m_axis_tvalid and
// m_axis_tready are both high. While tvalid is high and tready is low,
// tdata/tuser/tlast hold steady. din_valid has no backpressure: a frame that
// arrives while frame_ready is low is dropped and overflow is latched.
//
// Optional build macro: PFFT_BITREV_OUT_EN. When defined, the bank is read at
// bit_reverse(idx); tuser and tlast still follow the stream position idx.

module pfft_dout_serializer #(
  parameter int FFT_ORDER        = 3,
  parameter int COMPLEX_A_DWIDTH = 32
) (
  input  logic                                        aclk,
  input  logic                                        rst,
  input  logic                                        din_valid,
  input  logic [(2**FFT_ORDER)*COMPLEX_A_DWIDTH-1:0]  din_p,
  output logic                                        frame_ready,
  output logic                                        overflow,
  output logic [COMPLEX_A_DWIDTH-1:0]                 m_axis_tdata,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        m_axis_tlast,
  output logic [FFT_ORDER-1:0]                        m_axis_tuser
);

  localparam int N  = 2**FFT_ORDER;
  localparam int W  = COMPLEX_A_DWIDTH;
  localparam int FW = N * W;
  localparam logic [FFT_ORDER-1:0] IDX_LAST = FFT_ORDER'(N - 1);

  // Read side is IDLE with no buffered frame and STREAM otherwise.
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  rd_state_t              state;
  logic [FW-1:0]          bank [2];
  logic [1:0]             count;
  logic [1:0]             count_next;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [FFT_ORDER-1:0]   idx;
  logic [FFT_ORDER-1:0]   raddr;
  logic [FW-1:0]          rd_frame;
  logic                   beat;
  logic                   last_beat;
  logic                   capture;

  assign beat      = m_axis_tvalid & m_axis_tready;
  assign last_beat = beat & (idx == IDX_LAST);

  // A full buffer can still take a frame in the cycle its read bank is
  // released; the write pointer already points at that bank.
  assign frame_ready = (count != 2'd2) | last_beat;
  assign capture     = din_valid & frame_ready;

  assign m_axis_tuser = idx;
  assign m_axis_tlast = m_axis_tvalid & (idx == IDX_LAST);

  // Read address: stream position, optionally bit-reversed.
`ifdef PFFT_BITREV_OUT_EN
  always_comb begin
    raddr = '0;
    for (int b = 0; b < FFT_ORDER; b++) begin
      raddr[b] = idx[FFT_ORDER-1-b];
    end
  end
`else
  always_comb begin
    raddr = idx;
  end
`endif

  // Output sample mux from the current read bank.
  always_comb begin
    rd_frame     = bank[rd_ptr];
    m_axis_tdata = rd_frame[int'(raddr)*W +: W];
  end

  // Fill level after this edge: capture and release can cancel out.
  always_comb begin
    count_next = count;
    if (capture && !last_beat) begin
      count_next = count + 2'd1;
    end else if (!capture && last_beat) begin
      count_next = count - 2'd1;
    end
  end

  // Frame storage; contents are meaningless until counted as full.
  always_ff @(posedge aclk) begin
    if (capture) begin
      bank[wr_ptr] <= din_p;
    end
  end

  // Buffer bookkeeping, read FSM and registered stream valid.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      idx           <= '0;
      overflow      <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      count <= count_next;
      if (capture) begin
        wr_ptr <= ~wr_ptr;
      end
      if (beat) begin
        idx <= idx + FFT_ORDER'(1);
      end
      if (last_beat) begin
        rd_ptr <= ~rd_ptr;
      end
      if (din_valid && !frame_ready) begin
        overflow <= 1'b1;
      end
      state         <= (count_next != 2'd0) ? STREAM : IDLE;
      m_axis_tvalid <= (count_next != 2'd0);
    end
  end

endmodule

// File: doc/pfft_dout_serializer.md
Name: pfft_dout_serializer

Overview:
- Sits downstream of the parallel FFT core. Captures one full parallel output frame (2**FFT_ORDER complex samples) on each core output-valid pulse.
- Streams the frame out one complex sample per handshake on an AXI-Stream-style master port, with tlast on the last sample.
- Two-bank ping-pong buffer absorbs back-to-back core frames; overflow is flagged because the core has no backpressure.

Parameters:
- FFT_ORDER, 3, log2 of frame length; N = 2**FFT_ORDER samples per frame; legal range 1..10.
- COMPLEX_A_DWIDTH, 32, bits per complex sample: imag in the upper half, real in the lower half; passed through unmodified.

Ports:
- aclk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din_valid  in  1  one-cycle pulse: din_p holds a complete frame.
- din_p  in  N*COMPLEX_A_DWIDTH  parallel frame; sample k is at bits [k*COMPLEX_A_DWIDTH +: COMPLEX_A_DWIDTH].
- frame_ready  out  1  high when a din_valid this cycle would be accepted.
- overflow  out  1  sticky: a frame was dropped.
- m_axis_tdata  out  COMPLEX_A_DWIDTH  current sample.
- m_axis_tvalid  out  1  sample valid.
- m_axis_tready  in  1  downstream accepts.
- m_axis_tlast  out  1  high on the last sample of a frame.
- m_axis_tuser  out  FFT_ORDER  frequency-bin index of the current sample.

Behaviour:
- Reset (rst=1 at an edge):
  - both banks empty; write pointer, read pointer and sample index = 0;
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, overflow=0, frame_ready=1;
  - m_axis_tdata is don't-care while tvalid=0.
  - Reset mid-frame discards all buffered data; no partial frame resumes.
- State:
  - fill count (0,1,2), write bank pointer, read bank pointer, sample index idx (FFT_ORDER bits).
  - Read states: IDLE (count==0) and STREAM (count>0).
- Capture:
  - At an edge with din_valid=1 and frame_ready=1, all of din_p is written into the write bank; the write pointer toggles and count increments.
  - frame_ready = (count<2) OR (count==2 AND a tlast handshake occurs this cycle).
  - Simultaneous capture and last-sample release: count stays unchanged and the freed bank is reused. The freed bank is the read bank; the write pointer already points at it.
- Drop:
  - din_valid=1 with frame_ready=0: the frame is discarded, buffered banks are untouched, and overflow is set.
  - overflow clears only on rst.
- Output:
  - m_axis_tvalid = (count>0).
  - m_axis_tdata = read bank, sample idx (combinational mux from registered state).
  - m_axis_tuser = idx; m_axis_tlast = tvalid AND (idx==N-1).
  - Latency: a frame captured at edge E is presented with tvalid=1 in the cycle after E when count was 0 before E.
- Handshake:
  - Beat transfers when tvalid AND tready. idx increments on each beat.
  - On a tlast beat: idx wraps to 0, the read pointer toggles, and count decrements (unless a simultaneous capture occurs).
  - If the other bank is full, its sample 0 appears the next cycle with no bubble.
  - While tvalid=1 and tready=0, tdata, tuser and tlast hold stable (AXI rule).
- Ordering: samples are emitted in natural index order 0..N-1.
- Width rules: no arithmetic on data. idx is an FFT_ORDER-bit counter; wrap is natural at N-1. FFT_ORDER=1 gives a 1-bit idx with alternating tlast.

Optional Feature:
- Macro: PFFT_BITREV_OUT_EN.
- Defined: the read address is bit_reverse(idx) over FFT_ORDER bits. m_axis_tuser still reports idx (the stream position); tlast remains at idx==N-1. For N=8, the emitted bank samples are 0,4,2,6,1,5,3,7.
- Undefined: natural order as described in Behaviour.
- Capture, handshake and overflow behaviour are identical in both builds.

Test Plan:
- Single frame, N=8, sample k = {16'(k+0x10), 16'(k)}, tready=1 -> 8 beats on consecutive cycles starting one cycle after capture; tuser 0..7; tlast only on beat 7; then tvalid=0.
- Same frame with tready toggling 1,0,0,1 repeating -> the same 8 values in order; tdata, tuser and tlast hold steady during every stall; no duplicate or lost beats.
- Two frames with din_valid 3 cycles apart, tready=1 -> 16 contiguous beats with no bubble at the frame boundary; 2 tlast pulses; overflow=0.
- tready=0, three din_valid pulses -> frame_ready=0 after the 2nd; 3rd dropped; overflow=1; releasing tready yields exactly frames 1 then 2.
- count==2 with a din_valid in the same cycle as the tlast handshake -> frame accepted; overflow stays 0; the next 16 beats are frame 2 then frame 3.
- rst asserted at beat 3 of a frame -> next cycle tvalid=0, overflow=0, frame_ready=1; a new frame then starts from tuser=0. With PFFT_BITREV_OUT_EN, the single-frame test emits sample indices 0,4,2,6,1,5,3,7.
